// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame layout and
// helpers that turn physical time parameters into system clock cycles.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INHIBIT  = 3'd1,
      RTS      = 3'd2,
      SEND     = 3'd3,
      ACK      = 3'd4,
      WAIT_REL = 3'd5
   } ps2_state_e;

   localparam int   PS2_FRAME_BITS = 10;
   localparam logic PS2_ACK_BIT    = 1'b0;

   function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
      return (clk_hz / 1_000_000) * us;
   endfunction

   function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a one-cycle falling-edge strobe.
// Flops reset to 1 (idle line level) so reset never fakes an edge.
module ps2_line_sync (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iLine,
   output logic oSync,
   output logic oFall
);

   logic [1:0] meta_q;
   logic       prev_q;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         meta_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         meta_q <= {meta_q[0], iLine};
         prev_q <= meta_q[1];
      end
   end

   assign oSync = meta_q[1];
   assign oFall = prev_q & ~meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock
// out a 10-bit frame on device clock falls, then collect the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned INHIBIT_US  = 100,
   parameter int unsigned TIMEOUT_MS  = 15
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iStart,
   input  logic [7:0] iData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError,
   input  logic       iPS2clk,
   input  logic       iPS2data,
   output logic       oPS2clk_oe,
   output logic       oPS2data_oe
);

   localparam int unsigned INH_CYC = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
   localparam int unsigned TO_CYC  = ms_to_cyc(CLK_FREQ_HZ, TIMEOUT_MS);
   localparam int          IW      = $clog2(INH_CYC + 1);
   localparam int          TW      = $clog2(TO_CYC + 1);

   ps2_state_e                state_q, state_d;
   logic [PS2_FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]                bitcnt_q, bitcnt_d;
   logic [IW-1:0]             inh_q, inh_d;
   logic [TW-1:0]             tmr_q, tmr_d;
   logic                      err_pend_q, err_pend_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      clk_oe_q, clk_oe_d;
   logic                      data_oe_q, data_oe_d;

   logic clk_s, clk_fall, data_s, data_fall_unused;

   ps2_line_sync u_clk_sync (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iLine  (iPS2clk),
      .oSync  (clk_s),
      .oFall  (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iLine  (iPS2data),
      .oSync  (data_s),
      .oFall  (data_fall_unused)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bitcnt_d   = bitcnt_q;
      inh_d      = inh_q;
      tmr_d      = tmr_q;
      err_pend_d = err_pend_q;
      data_oe_d  = data_oe_q;
      done_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            // busy_q is still high during the oDone cycle, so a start there is dropped
            if (iStart && !busy_q) begin
               shreg_d    = {1'b1, ~^iData, iData};
               err_d      = 1'b0;
               err_pend_d = 1'b0;
               inh_d      = '0;
               state_d    = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_q == IW'(INH_CYC - 1)) begin
               state_d   = RTS;
               data_oe_d = 1'b1;
            end else begin
               inh_d = inh_q + 1'b1;
            end
         end
         RTS: begin
            state_d  = SEND;
            bitcnt_d = '0;
            tmr_d    = '0;
         end
         SEND: begin
            if (clk_fall) begin
               data_oe_d = ~shreg_q[0];
               shreg_d   = {1'b0, shreg_q[PS2_FRAME_BITS-1:1]};
               bitcnt_d  = bitcnt_q + 1'b1;
               if (bitcnt_q == 4'(PS2_FRAME_BITS - 1)) state_d = ACK;
            end
         end
         ACK: begin
            if (clk_fall) begin
               err_pend_d = (data_s != PS2_ACK_BIT);
               state_d    = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               err_d   = err_pend_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Timeout overrides anything the device did in the same cycle
      if (state_q inside {SEND, ACK, WAIT_REL}) begin
         tmr_d = tmr_q + 1'b1;
         if (tmr_q == TW'(TO_CYC - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end
      end

      if (state_d inside {IDLE, INHIBIT, ACK, WAIT_REL}) data_oe_d = 1'b0;
      clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
      busy_d   = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         inh_q      <= '0;
         tmr_q      <= '0;
         err_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
         inh_q      <= inh_d;
         tmr_q      <= tmr_d;
         err_pend_q <= err_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
      end
   end

   assign oBusy       = busy_q;
   assign oDone       = done_q;
   assign oError      = err_q;
   assign oPS2clk_oe  = clk_oe_q;
   assign oPS2data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a 10 kHz keyboard model clocks frames out of the host;
// a scoreboard monitor checks every oDone against frames computed from the byte.
module tb_ps2_host_tx;

   localparam int unsigned CLK_HZ  = 1_000_000;
   localparam int unsigned INH_US  = 100;
   localparam int unsigned TO_MS   = 2;
   localparam int          INH_CYC = 100;
   localparam int          TO_CYC  = 2000;
   localparam int          HALF    = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data = '0;
   logic       busy, done, err, clk_oe, data_oe;
   logic       dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
   logic       ps2clk, ps2data;

   assign ps2clk  = ~(clk_oe | dev_clk_pull);
   assign ps2data = ~(data_oe | dev_data_pull);

   always #5 clk = ~clk;

   ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_MS(TO_MS)) dut (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .iData(data),
      .oBusy(busy), .oDone(done), .oError(err),
      .iPS2clk(ps2clk), .iPS2data(ps2data),
      .oPS2clk_oe(clk_oe), .oPS2data_oe(data_oe)
   );

   typedef struct {
      logic [7:0] d;
      bit         exp_err;
      bit         timeout;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] dev_q[$];
   int          checks = 0, errors = 0;
   int          cyc = 0;
   int          dev_falls = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Line image of a frame as the device sees it: start, data LSB first, odd parity, stop
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         ones += int'(d[i]);
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Monitor: inhibit/RTS timing and scoreboard compare on every oDone
   bit prev_done = 0, prev_rts = 0;
   int inh_run = 0, rts_run = 0, rts_cyc = 0;
   always @(negedge clk) begin : mon
      exp_t e;
      bit   both;
      if (!rst_n) begin
         prev_done = 0; prev_rts = 0; inh_run = 0; rts_run = 0;
      end else begin
         if (prev_done) chk("busy_fall_after_done", busy, 0);
         prev_done = done;
         if (done) begin
            chk("busy_at_done", busy, 1);
            chk("lines_released_at_done", {clk_oe, data_oe}, 0);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: got oDone=1, expected no pending transfer");
            end else begin
               e = exp_q.pop_front();
               chk("error_flag", err, e.exp_err);
               if (e.timeout) begin
                  chk("timeout_window", (cyc - rts_cyc >= TO_CYC) && (cyc - rts_cyc <= TO_CYC + 2), 1);
               end else if (dev_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL frame_missing: got no device frame, expected one for 0x%0h", e.d);
               end else begin
                  chk("frame_bits", dev_q.pop_front(), ref_frame(e.d));
               end
            end
         end
         both = clk_oe && data_oe;
         if (clk_oe && !data_oe) inh_run++;
         if (both) begin
            if (!prev_rts) begin
               chk("inhibit_len", inh_run, INH_CYC);
               rts_cyc = cyc;
               rts_run = 0;
            end
            rts_run++;
         end else if (prev_rts) begin
            chk("rts_len", rts_run, 1);
         end
         if (!clk_oe) inh_run = 0;
         prev_rts = both;
      end
   end

   task automatic send(input logic [7:0] d, input bit exp_err, input bit timeout, input bit push);
      exp_t e;
      @(negedge clk);
      chk("idle_not_busy", busy, 0);
      start = 1'b1;
      data  = d;
      if (push) begin
         e.d = d; e.exp_err = exp_err; e.timeout = timeout;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      data  = $urandom;
      chk("busy_after_start", busy, 1);
   endtask

   // Keyboard model: samples data while clock is high, then pulls clock low
   task automatic device(input bit ack, input bit clocks, input bit record);
      logic [10:0] bits;
      int n = 0;
      dev_falls = 0;
      bits = '0;
      while (!(clk_oe && data_oe) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL rts_wait: got no request-to-send within %0d cycles", n);
         return;
      end
      repeat (2) @(negedge clk);
      if (!clocks) return;
      for (int i = 0; i < 11; i++) begin
         repeat (HALF) @(negedge clk);
         bits[i] = ps2data;
         if (i == 10 && ack) begin
            dev_data_pull = 1'b1;
            @(negedge clk);
         end
         dev_clk_pull = 1'b1;
         dev_falls++;
         repeat (HALF) @(negedge clk);
         dev_clk_pull = 1'b0;
      end
      if (record) dev_q.push_back(bits);
      repeat (HALF) @(negedge clk);
      dev_data_pull = 1'b0;
   endtask

   task automatic wait_falls(input int k);
      int n = 0;
      while (dev_falls < k && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL fall_wait: got %0d device falls, expected %0d", dev_falls, k);
      end
   endtask

   task automatic xfer(input logic [7:0] d, input bit ack);
      fork
         send(d, !ack, 1'b0, 1'b1);
         device(ack, 1'b1, 1'b1);
      join
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [7:0] rd;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_error", err, 0);
      chk("reset_clk_oe", clk_oe, 0);
      chk("reset_data_oe", data_oe, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      xfer(8'hED, 1'b1);
      xfer(8'h00, 1'b1);
      xfer(8'h01, 1'b1);
      xfer(8'h5A, 1'b0);
      chk("nack_lines_after", {clk_oe, data_oe}, 0);

      // Device never clocks: timeout path
      fork
         send(8'h3C, 1'b1, 1'b1, 1'b1);
         device(1'b0, 1'b0, 1'b0);
      join
      repeat (TO_CYC + 50) @(negedge clk);
      chk("timeout_idle_busy", busy, 0);
      chk("timeout_lines", {clk_oe, data_oe}, 0);

      // Second iStart mid-frame must be ignored
      fork
         send(8'hA5, 1'b0, 1'b0, 1'b1);
         device(1'b1, 1'b1, 1'b1);
         begin
            wait_falls(4);
            @(negedge clk);
            start = 1'b1; data = 8'h5A;
            @(negedge clk);
            start = 1'b0;
         end
      join
      repeat (100) @(negedge clk);

      // Reset at bit 5 of an all-zero byte (data_oe is high there)
      fork
         send(8'h00, 1'b0, 1'b0, 1'b0);
         device(1'b1, 1'b1, 1'b0);
         begin
            wait_falls(5);
            repeat (10) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midreset_clk_oe", clk_oe, 0);
            chk("midreset_data_oe", data_oe, 0);
            chk("midreset_busy", busy, 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      repeat (200) @(negedge clk);
      xfer(8'hC3, 1'b1);

      for (int k = 0; k < 4; k++) begin
         rd = 8'($urandom);
         xfer(rd, 1'($urandom_range(0, 1)));
      end

      repeat (200) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("device_frames_drained", dev_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected end within 100000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte from the core to the attached keyboard, for example 0xED (set LEDs) followed by the LED mask. It is the counterpart of the existing PS/2 scan-code receiver, which owns the inbound direction. It drives the PS/2 clock and data lines as open-drain: an output enable of 1 pulls the line low. The block runs entirely in the system clock domain and samples the PS/2 lines through synchronizers.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
INHIBIT_US, 100, time the host holds PS/2 clock low before the request-to-send, in µs.
TIMEOUT_MS, 15, maximum time from request-to-send until the device acknowledges, in ms.

Ports:
iClk  in  1  system clock.
iRst_n  in  1  asynchronous, active-low reset.
iStart  in  1  one-cycle request to send iData; accepted only when oBusy=0.
iData  in  8  command byte; sampled in the cycle iStart is accepted.
oBusy  out  1  transfer in progress.
oDone  out  1  one-cycle pulse when a transfer ends, whether it succeeded or failed.
oError  out  1  set with oDone when the device NACKed or the transfer timed out; held until the next accepted iStart.
iPS2clk  in  1  raw PS/2 clock line (asynchronous).
iPS2data  in  1  raw PS/2 data line (asynchronous).
oPS2clk_oe  out  1  1 = pull the PS/2 clock line low.
oPS2data_oe  out  1  1 = pull the PS/2 data line low.

Behaviour:
- Reset (asynchronous, iRst_n=0):
  - state=IDLE; all outputs 0, so both lines are released.
  - Counters and shift register are cleared.
  - Reset mid-transfer releases both lines immediately; no oDone is generated.
- Sampling: iPS2clk and iPS2data each pass through a 2-FF synchronizer. A PS/2 clock fall is detected as sync_prev=1 and sync=0, giving a 1-cycle strobe.
- Derived constants:
  - INH_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US.
  - TO_CYC = CLK_FREQ_HZ/1000*TIMEOUT_MS.
  - The timer is sized by $clog2(TO_CYC+1).
- IDLE: oBusy=0. When iStart=1:
  - Latch shreg = {stop=1, parity=~^iData, iData}, a 10-bit frame sent LSB first.
  - Clear oError and go to INHIBIT.
  - oBusy rises on the next edge.
- INHIBIT: oPS2clk_oe=1 and oPS2data_oe=0 for INH_CYC cycles. Then go to RTS.
- RTS (1 cycle): oPS2clk_oe=1 and oPS2data_oe=1, which places the start bit on the line. Then go to SEND with bitcnt=0 and the timeout timer cleared. From this point oPS2clk_oe=0.
- SEND: oPS2data_oe holds the current bit inverted (oe = ~bit).
  - Start bit: oe stays 1 until the first clock fall.
  - On each clock fall: drive ~shreg[0], shift shreg right, bitcnt++.
  - Bits 1–8 are data LSB first, bit 9 is parity, bit 10 is stop (line released).
  - After the fall that puts the stop bit out (bitcnt=10), go to ACK.
- ACK: both lines released. On the next clock fall, sample the synchronized data line:
  - 0 = ACK: go to WAIT_REL.
  - 1 = NACK: set err_pending and go to WAIT_REL.
- WAIT_REL: wait until the synchronized clock and data are both 1. Then pulse oDone, set oError=err_pending, and go to IDLE.
- Timeout:
  - The timer counts in SEND, ACK and WAIT_REL.
  - When it reaches TO_CYC: release both lines, pulse oDone with oError=1, and go to IDLE.
  - Timeout has priority over a clock fall in the same cycle.
- While oBusy=1, iStart is ignored and iData is not sampled.
- A clock fall seen in IDLE, INHIBIT or RTS is ignored. That traffic is device-to-host and belongs to the receiver.
- Data changes only on clock falls; the device samples on rising edges.

Decomposition:
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_REL;
  - PS2_FRAME_BITS=10 and PS2_ACK_BIT=0;
  - cycle-count helper functions.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge strobe for one line. It is instantiated for both clock and data, and can later be reused by the receiver.

Test Plan:
- Bench params CLK_FREQ_HZ=1_000_000, INHIBIT_US=100, TIMEOUT_MS=2. Device model clocks at 10 kHz.
- Send 0xED, device ACKs:
  - oPS2clk_oe is high for exactly 100 cycles, then RTS.
  - The device samples start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - oDone pulses once with oError=0; oBusy=1 from the cycle after iStart until the cycle after oDone.
- Send 0x00, device ACKs: parity bit is 1. Send 0x01: parity bit is 0.
- Device NACK (data high at the 11th clock fall): oDone with oError=1, both oe=0 afterwards.
- Device never clocks after RTS: after 2000 cycles, oDone with oError=1, lines released, block back in IDLE.
- iStart pulsed at bit 4 of a transfer with a different iData: ignored, and the original frame completes unchanged.
- iRst_n asserted at bit 5: oPS2clk_oe=oPS2data_oe=0 and oBusy=0 immediately, no oDone. A following iStart sends a full correct frame.
